mc_luma_mb_buf: RTL and testbench
=================================

# mc_luma_mb_buf

Macroblock reconstruction buffer directly downstream of the luma motion-compensation selector. It accepts the 8-pixel predicted-luma words written each valid cycle, assembles them into a complete 16x16 predicted macroblock, and streams the finished macroblock out as 16 rows of 16 pixels over a valid/ready handshake to the residual stage. Optional ping-pong banking lets filling of macroblock N+1 overlap draining of macroblock N.

## Interface
- BIT_DEPTH, `BIT_DEPTH` (8): pixel width, taken from enc_defines.v.
- clk_i  in  1  single clock; all state changes on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mc_luma_wren_i  in  1  write strobe from the MC luma selector.
- mc_luma_i  in  8*BIT_DEPTH  8 horizontally contiguous pixels; pixel 0 in bits [BIT_DEPTH-1:0].
- rd_valid_o  out  1  a full row is presented.
- rd_ready_i  in  1  consumer accepts the row when high with rd_valid_o.
- rd_data_o  out  16*BIT_DEPTH  row pixels; column 0 in LSBs.
- rd_row_o  out  4  row index 0..15 of rd_data_o.
- rd_last_o  out  1  high with row 15.
- mb_full_o  out  1  one-cycle pulse when a bank completes its 32nd write.
- overflow_o  out  1  sticky; set when a write is dropped.

## Operation
- Storage: per bank, 32 words x 8*BIT_DEPTH. Write k (0..31) goes to row k>>1, columns 0-7 when k even, 8-15 when k odd.
- Per bank state: EMPTY -> FILLING (first write) -> FULL (32nd write) -> DRAINING (first row accepted) -> EMPTY (row 15 accepted). FULL with 0 rows read and DRAINING are both "readable".
- Write pointer wr_bank, 5-bit wr_cnt. On 32nd write: wr_cnt wraps to 0, bank goes FULL, mb_full_o pulses, wr_bank toggles (ping-pong only).
- Write to a bank that is FULL or DRAINING: data dropped, wr_cnt unchanged, overflow_o set until reset.
- Read pointer rd_bank, 4-bit rd_row. rd_valid_o = read bank readable. rd_data_o = row rd_row of read bank, 0 when rd_valid_o low. Transfer on rd_valid_o & rd_ready_i: rd_row increments; on row 15 rd_row wraps to 0, bank returns EMPTY, rd_bank toggles (ping-pong only).
- rd_valid_o, once high, stays high until row 15 transfers, independent of rd_ready_i.
- Simultaneous write-complete on one bank and read-complete on the other: both take effect in the same cycle.
- Reset: all banks EMPTY, pointers and counters 0; storage contents not reset.

## Timing
- Reset values: rd_valid_o 0, rd_data_o 0, rd_row_o 0, rd_last_o 0, mb_full_o 0, overflow_o 0.
- Write of word k sampled at edge N; stored and visible at N+1.
- 32nd write at edge N: mb_full_o and rd_valid_o high in cycle N+1 (one-cycle fill-to-read latency).
- rd_data_o/rd_row_o/rd_last_o are combinational from registered state and storage; row advances one per accepted cycle, 16 cycles minimum per macroblock.
- Row 15 accepted at edge M: with single bank, a write at edge M is still dropped; bank accepts writes from edge M+1.
- Sustained throughput (ping-pong): 32 write cycles per macroblock with no drops, provided the consumer drains 16 rows within 32 cycles.

## Configuration
- MC_LUMA_BUF_PINGPONG_EN defined: two banks, pointers toggle as above; writes to the idle bank proceed while the other drains.
- Undefined: single bank, pointers never toggle; every write while the bank is FULL or DRAINING is dropped and sets overflow_o. Storage halves.

## Test plan
- Reset then 32 writes, word k = all pixels k: mb_full_o pulses once at cycle after write 31; row r reads pixels {2r+1 x8, 2r x8}; rd_last_o only at row 15.
- rd_ready_i held low 10 cycles after fill: rd_valid_o stays 1, rd_row_o stays 0, rd_data_o stable; then ready high -> 16 consecutive transfers.
- Ping-pong: 64 back-to-back writes, ready always high: no overflow_o, two macroblocks read in order, rows intact.
- Single bank (macro undefined): 33rd write while draining -> dropped, overflow_o 1 from next cycle, first macroblock reads unchanged.
- Both banks full (ping-pong), further write -> dropped, overflow_o 1; drain one bank, next write accepted into it at row 0.
- Assert rst_i after 17 writes and mid-drain: next cycle all outputs 0; a fresh 32-write sequence fills bank 0 correctly.

Source files
------------

// File: rtl/mc_luma_mb_buf.sv
// Assembles 8-pixel MC luma words into a 16x16 macroblock and streams it out row by row; MC_LUMA_BUF_PINGPONG_EN adds a second bank.
// Latency: one cycle from the 32nd write to mb_full_o/rd_valid_o; read data is combinational from registered state.
// Backpressure: rd_ready_i stalls rows; a write into a FULL/DRAINING bank is dropped and sets sticky overflow_o.
module mc_luma_mb_buf #(
    parameter int BIT_DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mc_luma_wren_i,
    input  logic [8*BIT_DEPTH-1:0] mc_luma_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [16*BIT_DEPTH-1:0] rd_data_o,
    output logic [3:0]             rd_row_o,
    output logic                   rd_last_o,
    output logic                   mb_full_o,
    output logic                   overflow_o
);

    localparam int WW = 8 * BIT_DEPTH;
`ifdef MC_LUMA_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = $clog2(NB * 32);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DRAINING
    } bank_st_e;

    logic [WW-1:0] mem [NB*32];

    logic [4:0]    wr_cnt_q;
    logic [3:0]    rd_row_q;
    logic          mb_full_q;
    logic          overflow_q;
    logic [NB-1:0] wr_sel;
    logic [NB-1:0] rd_sel;
    logic [NB-1:0] wr_open;
    logic [NB-1:0] readable;
    logic          wr_ok;
    logic          wr_fire;
    logic          wr_last;
    logic          rd_xfer;
    logic          rd_done;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr_lo;
    logic [AW-1:0] rd_addr_hi;

`ifdef MC_LUMA_BUF_PINGPONG_EN
    logic wr_bank_q;
    logic rd_bank_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_q ^ (wr_fire & wr_last);
            rd_bank_q <= rd_bank_q ^ rd_done;
        end
    end

    assign wr_sel     = {wr_bank_q, ~wr_bank_q};
    assign rd_sel     = {rd_bank_q, ~rd_bank_q};
    assign wr_addr    = {wr_bank_q, wr_cnt_q};
    assign rd_addr_lo = {rd_bank_q, rd_row_q, 1'b0};
    assign rd_addr_hi = {rd_bank_q, rd_row_q, 1'b1};
`else
    assign wr_sel     = 1'b1;
    assign rd_sel     = 1'b1;
    assign wr_addr    = wr_cnt_q;
    assign rd_addr_lo = {rd_row_q, 1'b0};
    assign rd_addr_hi = {rd_row_q, 1'b1};
`endif

    // Only the bank addressed by each pointer can accept a write or present a row.
    assign wr_ok      = |(wr_sel & wr_open);
    assign wr_fire    = mc_luma_wren_i & wr_ok;
    assign wr_last    = (wr_cnt_q == 5'd31);
    assign rd_valid_o = |(rd_sel & readable);
    assign rd_xfer    = rd_valid_o & rd_ready_i;
    assign rd_done    = rd_xfer & (rd_row_q == 4'd15);

    for (genvar g = 0; g < NB; g++) begin : g_bank
        bank_st_e st_q;
        bank_st_e st_d;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st_q <= ST_EMPTY;
            end else begin
                st_q <= st_d;
            end
        end

        always_comb begin
            st_d = st_q;
            if (wr_fire && wr_sel[g]) begin
                st_d = wr_last ? ST_FULL : ST_FILLING;
            end
            if (rd_xfer && rd_sel[g]) begin
                st_d = (rd_row_q == 4'd15) ? ST_EMPTY : ST_DRAINING;
            end
        end

        assign wr_open[g]  = (st_q == ST_EMPTY) || (st_q == ST_FILLING);
        assign readable[g] = (st_q == ST_FULL) || (st_q == ST_DRAINING);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q   <= 5'd0;
            rd_row_q   <= 4'd0;
            mb_full_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 5'd1;
            end
            if (rd_xfer) begin
                rd_row_q <= rd_row_q + 4'd1;
            end
            mb_full_q  <= wr_fire & wr_last;
            overflow_q <= overflow_q | (mc_luma_wren_i & ~wr_ok);
        end
    end

    // Pixel storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem[wr_addr] <= mc_luma_i;
        end
    end

    assign rd_data_o  = rd_valid_o ? {mem[rd_addr_hi], mem[rd_addr_lo]} : '0;
    assign rd_row_o   = rd_row_q;
    assign rd_last_o  = rd_valid_o & (rd_row_q == 4'd15);
    assign mb_full_o  = mb_full_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mc_luma_mb_buf.sv
// Self-checking bench for mc_luma_mb_buf: queue-of-macroblocks reference model plus directed literal checks.
module tb_mc_luma_mb_buf;

    localparam int BD = 8;
    localparam int WW = 8 * BD;
    localparam int RW = 16 * BD;
`ifdef MC_LUMA_BUF_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [16*RW-1:0] mb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          wren;
    logic [WW-1:0] wdata;
    logic          rd_ready;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic [3:0]    rd_row;
    logic          rd_last;
    logic          mb_full;
    logic          overflow;

    always #5 clk = ~clk;

    mc_luma_mb_buf #(.BIT_DEPTH(BD)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mc_luma_wren_i (wren),
        .mc_luma_i      (wdata),
        .rd_valid_o     (rd_valid),
        .rd_ready_i     (rd_ready),
        .rd_data_o      (rd_data),
        .rd_row_o       (rd_row),
        .rd_last_o      (rd_last),
        .mb_full_o      (mb_full),
        .overflow_o     (overflow)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Reference model: words being collected, then a FIFO of completed macroblocks.
    logic [WW-1:0] fill_w [32];
    int            fill_cnt = 0;
    mb_t           mbq [$];
    int            rd_row_m = 0;
    bit            ovf_m    = 1'b0;
    bit            full_m   = 1'b0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] word_of(input int v);
        logic [BD-1:0] p;
        p = v[BD-1:0];
        return {8{p}};
    endfunction

    function automatic logic [RW-1:0] row_lit(input int r, input int base);
        return {word_of(base + 2*r + 1), word_of(base + 2*r)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mbq.delete();
            fill_cnt = 0;
            rd_row_m = 0;
            ovf_m    = 1'b0;
            full_m   = 1'b0;
        end else begin
            bit  accept;
            bit  pop;
            mb_t mb;
            full_m = 1'b0;
            pop    = 1'b0;
            accept = wren && (fill_cnt > 0 || mbq.size() < NB);
            if (mbq.size() > 0 && rd_ready) begin
                if (rd_row_m == 15) begin
                    rd_row_m = 0;
                    pop = 1'b1;
                end else begin
                    rd_row_m++;
                end
            end
            if (wren && !accept) ovf_m = 1'b1;
            if (pop) void'(mbq.pop_front());
            if (accept) begin
                fill_w[fill_cnt] = wdata;
                fill_cnt++;
                if (fill_cnt == 32) begin
                    for (int r = 0; r < 16; r++) mb[r*RW +: RW] = {fill_w[2*r+1], fill_w[2*r]};
                    mbq.push_back(mb);
                    fill_cnt = 0;
                    full_m   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit v;
            v = (mbq.size() > 0);
            check("rd_valid", RW'(rd_valid), RW'(v));
            check("rd_data", rd_data, v ? mbq[0][rd_row_m*RW +: RW] : '0);
            check("rd_row", RW'(rd_row), RW'(rd_row_m));
            check("rd_last", RW'(rd_last), RW'(v && rd_row_m == 15));
            check("mb_full", RW'(mb_full), RW'(full_m));
            check("overflow", RW'(overflow), RW'(ovf_m));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wren = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_mb(input int base);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            wren = 1'b1; wdata = word_of(base + k);
        end
        @(negedge clk);
        wren = 1'b0;
    endtask

    task automatic drain_check(input int base);
        rd_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            check("drain_row", RW'(rd_row), RW'(r));
            check("drain_data", rd_data, row_lit(r, base));
            check("drain_last", RW'(rd_last), RW'(r == 15));
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("drain_done_valid", RW'(rd_valid), '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, RW'(rd_valid), '0);
        check({tag, "_data"}, rd_data, '0);
        check({tag, "_row"}, RW'(rd_row), '0);
        check({tag, "_last"}, RW'(rd_last), '0);
        check({tag, "_full"}, RW'(mb_full), '0);
        check({tag, "_ovf"}, RW'(overflow), '0);
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; rd_ready = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_all_zero("reset");
        rst = 1'b0;

        // Fill, stall the consumer, then drain.
        write_mb(0);
        check("fill_full_pulse", RW'(mb_full), RW'(1));
        check("fill_valid", RW'(rd_valid), RW'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", RW'(rd_valid), RW'(1));
            check("stall_row", RW'(rd_row), '0);
            check("stall_data", rd_data, row_lit(0, 0));
            check("stall_full", RW'(mb_full), '0);
        end
        drain_check(0);

        // Reset after partial fill, and again mid-drain.
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            wren = 1'b1; wdata = word_of(40 + k);
        end
        @(negedge clk);
        wren = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_fill");
        rst = 1'b0;
        write_mb(40);
        rd_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("middrain_row", RW'(rd_row), RW'(5));
        check("middrain_data", rd_data, row_lit(5, 40));
        rst = 1'b1; rd_ready = 1'b0;
        @(negedge clk);
        check_all_zero("rst_drain");
        rst = 1'b0;
        write_mb(80);
        check("refill_full_pulse", RW'(mb_full), RW'(1));
        drain_check(80);

`ifdef MC_LUMA_BUF_PINGPONG_EN
        // Back-to-back macroblocks with an always-ready consumer.
        do_reset();
        rd_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            wren = 1'b1; wdata = word_of(k);
            if (k == 40) begin
                check("pp_overlap_valid", RW'(rd_valid), RW'(1));
            end
        end
        @(negedge clk);
        wren = 1'b0;
        check("pp_second_row0", rd_data, row_lit(0, 32));
        repeat (20) @(negedge clk);
        check("pp_no_overflow", RW'(overflow), '0);
        check("pp_idle_valid", RW'(rd_valid), '0);

        // Both banks full: extra write dropped, then freed bank refills from row 0.
        do_reset();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            wren = 1'b1; wdata = word_of(100 + k);
        end
        @(negedge clk);
        wren = 1'b1; wdata = word_of(250);
        @(negedge clk);
        wren = 1'b0;
        check("pp_full_overflow", RW'(overflow), RW'(1));
        check("pp_full_data", rd_data, row_lit(0, 100));
        rd_ready = 1'b1;
        repeat (16) @(negedge clk);
        rd_ready = 1'b0;
        check("pp_second_bank", rd_data, row_lit(0, 132));
        write_mb(20);
        check("pp_refill_pulse", RW'(mb_full), RW'(1));
        drain_check(132);
        drain_check(20);
`else
        // Single bank: write while draining is dropped, including at the last-row edge.
        do_reset();
        write_mb(120);
        rd_ready = 1'b1; wren = 1'b1; wdata = word_of(255);
        @(negedge clk);
        wren = 1'b0;
        check("sb_overflow", RW'(overflow), RW'(1));
        for (int r = 1; r < 16; r++) begin
            check("sb_row", RW'(rd_row), RW'(r));
            check("sb_data", rd_data, row_lit(r, 120));
            if (r == 15) begin
                wren = 1'b1; wdata = word_of(200);
            end
            @(negedge clk);
            wren = 1'b0;
        end
        rd_ready = 1'b0;
        check("sb_empty", RW'(rd_valid), '0);
        write_mb(160);
        check("sb_refill_pulse", RW'(mb_full), RW'(1));
        drain_check(160);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
